// File: rtl/digit_result_tx_pkg.sv
// Shared types and constants for the classifier result transmitter.
package cnn_result_pkg;

    localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
    localparam int unsigned FRAME_BYTES    = 5;

    typedef logic [2:0] byte_idx_t;

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] val;
    } result_entry_t;

    // Byte n of a frame: header, {seq, class}, score MSB, score LSB, XOR checksum.
    function automatic logic [7:0] frame_byte(
        input result_entry_t entry,
        input logic [3:0]    seq,
        input byte_idx_t     idx,
        input logic [7:0]    header
    );
        logic [7:0] b1;
        b1 = {seq, entry.idx};
        case (idx)
            3'd0:    frame_byte = header;
            3'd1:    frame_byte = b1;
            3'd2:    frame_byte = entry.val[15:8];
            3'd3:    frame_byte = entry.val[7:0];
            3'd4:    frame_byte = header ^ b1 ^ entry.val[15:8] ^ entry.val[7:0];
            default: frame_byte = '0;
        endcase
    endfunction

endpackage

// File: rtl/digit_result_tx_if.sv
// Byte-wide valid/ready stream toward the UART/PS bridge.
interface digit_result_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/digit_result_tx_fifo.sv
// Synchronous FIFO with a combinational head read (first-word fall-through).
module result_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("result_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/digit_result_tx.sv
// Buffers classifier decisions and streams each as a 5-byte checksummed frame.
module digit_result_tx
    import cnn_result_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_MATS     = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  HEADER     = HEADER_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     max_in,
    input  logic [$clog2(N_MATS)-1:0] index_in,
    input  logic                      valid_in,
    digit_result_tx_if.master         tx,
    output logic                      busy,
    output logic                      overflow,
    output logic [7:0]                frame_cnt
);
    if (DATA_WIDTH != 16) begin : g_bad_width
        $error("digit_result_tx: DATA_WIDTH must be 16");
    end
    if ($clog2(N_MATS) > 4) begin : g_bad_classes
        $error("digit_result_tx: $clog2(N_MATS) must be <= 4");
    end

    tx_state_t     state, state_d;
    byte_idx_t     byte_idx, byte_idx_d;
    result_entry_t frame_q, frame_d, head, push_entry;
    logic [3:0]    seq_q, seq_d;
    logic [7:0]    cnt_d;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic          hs, last_hs, drop;

    assign push_entry = {4'(index_in), max_in};
    assign hs         = (state == SEND) && tx.tx_ready;
    assign last_hs    = hs && (byte_idx == byte_idx_t'(FRAME_BYTES - 1));
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign fifo_push  = valid_in && !rst && (!fifo_full || fifo_pop);
    assign drop       = valid_in && !fifo_push;

    result_fifo #(
        .WIDTH ($bits(result_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic: load a frame when idle, advance bytes, reload back-to-back.
    always_comb begin
        state_d    = state;
        byte_idx_d = byte_idx;
        frame_d    = frame_q;
        seq_d      = seq_q;
        cnt_d      = frame_cnt;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    byte_idx_d = byte_idx_t'(byte_idx + 3'd1);
                    if (last_hs) begin
                        cnt_d = frame_cnt + 8'd1;
                        if (!fifo_empty) fifo_pop = 1'b1;
                        else             state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // seq follows the post-increment count so a reloaded frame gets the next number.
        if (fifo_pop) begin
            frame_d    = head;
            seq_d      = cnt_d[3:0];
            byte_idx_d = '0;
        end
    end

    // State, frame register, counters and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_idx  <= '0;
            frame_q   <= '0;
            seq_q     <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            byte_idx  <= byte_idx_d;
            frame_q   <= frame_d;
            seq_q     <= seq_d;
            frame_cnt <= cnt_d;
            overflow  <= overflow | drop;
        end
    end

    // Stream outputs, all derived from registered state.
    always_comb begin
        tx.tx_valid = (state == SEND);
        tx.tx_last  = (state == SEND) && (byte_idx == byte_idx_t'(FRAME_BYTES - 1));
        tx.tx_data  = (state == SEND) ? frame_byte(frame_q, seq_q, byte_idx, HEADER) : '0;
        busy        = (state != IDLE) || !fifo_empty;
    end

endmodule
